// File: rtl/fp_pkg.sv
// Shared definitions for the Fp add/sub digit-serial datapath: FSM encoding and
// digit-counter width helper.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2
    } fp_state_t;

    localparam int FP_DIGITS = 14;
    localparam int FP_CNT_W  = $clog2(FP_DIGITS);

    // Counter width for a digit index; never narrower than one bit.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/unit_adder.sv
// Combinational single-digit adder: {carry_out, sum} = a + b + carry_in.
module unit_adder #(
    parameter int RADIX = 32
) (
    input  logic [RADIX-1:0] a,
    input  logic [RADIX-1:0] b,
    input  logic             carry_in,
    output logic [RADIX-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{RADIX{1'b0}}, carry_in};

endmodule

// File: rtl/unit_subtractor.sv
// Combinational single-digit subtractor: {borrow_out, dout} = a - b - borrow_in.
module unit_subtractor #(
    parameter int RADIX = 32
) (
    input  logic [RADIX-1:0] a,
    input  logic [RADIX-1:0] b,
    input  logic             borrow_in,
    output logic [RADIX-1:0] dout,
    output logic             borrow_out
);

    // One extra bit catches the wrap-around, which is exactly the borrow.
    assign {borrow_out, dout} = {1'b0, a} - {1'b0, b} - {{RADIX{1'b0}}, borrow_in};

endmodule

// File: rtl/fp_subtractor.sv
// Digit-serial A - B - borrow_in, LSD first. With FP_SUB_CORRECT_EN defined the
// difference is buffered and p is added back when the raw result is negative.
module fp_subtractor
    import fp_pkg::*;
#(
    parameter int RADIX  = 32,
    parameter int DIGITS = 14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            borrow_in,
    input  logic                            digit_in_valid,
    input  logic [RADIX-1:0]                digit_a,
    input  logic [RADIX-1:0]                digit_b,
    output logic                            digit_out_valid,
    output logic [RADIX-1:0]                digit_res,
    output logic                            done,
    output logic                            borrow_out
`ifdef FP_SUB_CORRECT_EN
    ,
    output logic                            p_rd_en,
    output logic [cnt_width(DIGITS)-1:0]    p_rd_addr,
    input  logic [RADIX-1:0]                p_digit
`endif
);

    localparam int CW = cnt_width(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    fp_state_t        state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             borrow_reg, borrow_next;
    logic             dov_reg, dov_next;
    logic [RADIX-1:0] res_reg, res_next;
    logic             done_reg, done_next;
    logic             bout_reg, bout_next;

    logic [RADIX-1:0] sub_d;
    logic             sub_b;

    unit_subtractor #(.RADIX(RADIX)) u_sub (
        .a          (digit_a),
        .b          (digit_b),
        .borrow_in  (borrow_reg),
        .dout       (sub_d),
        .borrow_out (sub_b)
    );

`ifdef FP_SUB_CORRECT_EN
    logic             p_rd_en_reg, p_rd_en_next;
    logic [CW-1:0]    p_rd_addr_reg, p_rd_addr_next;
    logic             rd_valid_reg;
    logic             carry_reg, carry_next;
    logic [RADIX-1:0] res_buf [DIGITS];
    logic [RADIX-1:0] buf_rdata_reg;
    logic [RADIX-1:0] corr_addend;
    logic [RADIX-1:0] add_sum;
    logic             add_c;

    assign corr_addend = bout_reg ? p_digit : '0;

    unit_adder #(.RADIX(RADIX)) u_add (
        .a         (buf_rdata_reg),
        .b         (corr_addend),
        .carry_in  (carry_reg),
        .sum       (add_sum),
        .carry_out (add_c)
    );

    // Raw difference buffer; read port is registered so it lines up with p_digit.
    always_ff @(posedge clk) begin
        if (state_reg == SUB && digit_in_valid)
            res_buf[cnt_reg] <= sub_d;
        if (p_rd_en_reg)
            buf_rdata_reg <= res_buf[p_rd_addr_reg];
    end

    assign p_rd_en   = p_rd_en_reg;
    assign p_rd_addr = p_rd_addr_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        borrow_next = borrow_reg;
        dov_next    = 1'b0;
        res_next    = res_reg;
        done_next   = 1'b0;
        bout_next   = bout_reg;
`ifdef FP_SUB_CORRECT_EN
        p_rd_en_next   = 1'b0;
        p_rd_addr_next = p_rd_addr_reg;
        carry_next     = carry_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = SUB;
                    cnt_next    = '0;
                    borrow_next = borrow_in;
                end
            end
            SUB: begin
                if (digit_in_valid) begin
                    borrow_next = sub_b;
                    cnt_next    = cnt_reg + CW'(1);
`ifndef FP_SUB_CORRECT_EN
                    dov_next    = 1'b1;
                    res_next    = sub_d;
`endif
                    if (cnt_reg == LAST) begin
                        bout_next = sub_b;
                        cnt_next  = '0;
`ifdef FP_SUB_CORRECT_EN
                        state_next     = CORR;
                        p_rd_en_next   = 1'b1;
                        p_rd_addr_next = '0;
                        carry_next     = 1'b0;
`else
                        done_next  = 1'b1;
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef FP_SUB_CORRECT_EN
            CORR: begin
                // Read issue runs one cycle ahead of the output stage.
                if (p_rd_en_reg && p_rd_addr_reg != LAST) begin
                    p_rd_en_next   = 1'b1;
                    p_rd_addr_next = p_rd_addr_reg + CW'(1);
                end
                if (rd_valid_reg) begin
                    dov_next   = 1'b1;
                    res_next   = add_sum;
                    carry_next = add_c;
                    cnt_next   = cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            dov_reg    <= 1'b0;
            res_reg    <= '0;
            done_reg   <= 1'b0;
            bout_reg   <= 1'b0;
`ifdef FP_SUB_CORRECT_EN
            p_rd_en_reg   <= 1'b0;
            p_rd_addr_reg <= '0;
            rd_valid_reg  <= 1'b0;
            carry_reg     <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            borrow_reg <= borrow_next;
            dov_reg    <= dov_next;
            res_reg    <= res_next;
            done_reg   <= done_next;
            bout_reg   <= bout_next;
`ifdef FP_SUB_CORRECT_EN
            p_rd_en_reg   <= p_rd_en_next;
            p_rd_addr_reg <= p_rd_addr_next;
            rd_valid_reg  <= p_rd_en_reg;
            carry_reg     <= carry_next;
`endif
        end
    end

    assign digit_out_valid = dov_reg;
    assign digit_res       = res_reg;
    assign done            = done_reg;
    assign borrow_out      = bout_reg;

endmodule

// File: tb/tb_fp_subtractor.sv
// Bench for fp_subtractor (RADIX=8, DIGITS=4); whole-word reference model,
// builds with or without FP_SUB_CORRECT_EN.
module tb_fp_subtractor;

    localparam int R  = 8;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int W  = R * D;
    localparam logic [W-1:0] P = 32'h000000FB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         borrow_in;
    logic         digit_in_valid;
    logic [R-1:0] digit_a;
    logic [R-1:0] digit_b;
    logic         digit_out_valid;
    logic [R-1:0] digit_res;
    logic         done;
    logic         borrow_out;
`ifdef FP_SUB_CORRECT_EN
    logic          p_rd_en;
    logic [AW-1:0] p_rd_addr;
    logic [R-1:0]  p_digit;
    logic [R-1:0]  p_mem [D];
`endif

    fp_subtractor #(.RADIX(R), .DIGITS(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .borrow_in       (borrow_in),
        .digit_in_valid  (digit_in_valid),
        .digit_a         (digit_a),
        .digit_b         (digit_b),
        .digit_out_valid (digit_out_valid),
        .digit_res       (digit_res),
        .done            (done),
        .borrow_out      (borrow_out)
`ifdef FP_SUB_CORRECT_EN
        ,
        .p_rd_en         (p_rd_en),
        .p_rd_addr       (p_rd_addr),
        .p_digit         (p_digit)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Whole-word reference: bit W is the raw borrow, low W bits the result.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
`ifdef FP_SUB_CORRECT_EN
        if (d[W]) d[W-1:0] = d[W-1:0] + P;
`endif
        return d;
    endfunction

    logic [R:0] exp_q[$];
    int         exp_cyc_q[$];
    logic       exp_bout;
    int         last_in_cyc;
    int         done_cyc;
    bit         done_seen;
    int         rd_idx;

`ifdef FP_SUB_CORRECT_EN
    initial begin
        p_mem[0] = P[7:0];
        p_mem[1] = P[15:8];
        p_mem[2] = P[23:16];
        p_mem[3] = P[31:24];
    end
    always @(posedge clk) if (p_rd_en) p_digit <= p_mem[p_rd_addr];
`endif

    // Single compare process against the model queue.
    always @(negedge clk) begin
        if (digit_out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_digit", 1, 0);
            end else begin
                logic [R:0] e;
                int ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("digit_res", digit_res, e[R-1:0]);
                check("done_with_last", done, e[R]);
                check("digit_cycle", cyc, ec);
                if (e[R]) check("borrow_out", borrow_out, exp_bout);
            end
        end else if (done) begin
            check("done_without_valid", 1, 0);
        end
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
`ifdef FP_SUB_CORRECT_EN
        if (p_rd_en) begin
            check("p_rd_addr", p_rd_addr, rd_idx);
            if (rd_idx == 0) check("p_rd_en_start", cyc, last_in_cyc + 1);
            rd_idx++;
        end
`endif
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int gap_before, input int gap_len, input bit restart_mid,
                          input bit stop_after2);
        logic [W:0] m;
        m = model(a, b, bin);
        exp_bout  = m[W];
        done_seen = 1'b0;
        rd_idx    = 0;
        for (int k = 0; k < D; k++) exp_q.push_back({(k == D-1), m[k*R +: R]});
        @(posedge clk); #1;
        start = 1'b1; borrow_in = bin;
        @(posedge clk); #1;
        start = 1'b0; borrow_in = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (stop_after2 && k == 3) break;
            if (k == gap_before) begin
                digit_in_valid = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            digit_in_valid = 1'b1;
            digit_a = a[k*R +: R];
            digit_b = b[k*R +: R];
            if (restart_mid && k == 1) begin
                start = 1'b1; borrow_in = ~bin;
            end
`ifndef FP_SUB_CORRECT_EN
            exp_cyc_q.push_back(cyc + 1);
`endif
            last_in_cyc = cyc;
            @(posedge clk); #1;
            start = 1'b0; borrow_in = 1'b0;
        end
        digit_in_valid = 1'b0;
`ifdef FP_SUB_CORRECT_EN
        for (int k = 0; k < D; k++) exp_cyc_q.push_back(last_in_cyc + 3 + k);
`endif
        if (stop_after2) return;
        for (int i = 0; i < 30 && !done_seen; i++) @(posedge clk);
        #1;
        check("done_seen", done_seen, 1);
`ifdef FP_SUB_CORRECT_EN
        check("done_latency", done_cyc - last_in_cyc, D + 2);
        check("p_rd_count", rd_idx, D);
`else
        check("done_latency", done_cyc - last_in_cyc, 1);
`endif
        check("queue_drained", exp_q.size(), 0);
        $display("op a=%08h b=%08h bin=%0d -> exp=%08h borrow=%0d", a, b, bin, m[W-1:0], m[W]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dov"}, digit_out_valid, 0);
        check({tag, "_res"}, digit_res, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bout"}, borrow_out, 0);
`ifdef FP_SUB_CORRECT_EN
        check({tag, "_p_rd_en"}, p_rd_en, 0);
        check({tag, "_p_rd_addr"}, p_rd_addr, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; borrow_in = 1'b0; digit_in_valid = 1'b0;
        digit_a = '0; digit_b = '0;

        // Hand-computed pins on the model itself.
        check("pin_5m3", model(32'd5, 32'd3, 1'b0), 33'h0_00000002);
        check("pin_5m3b", model(32'd5, 32'd3, 1'b1), 33'h0_00000001);
`ifdef FP_SUB_CORRECT_EN
        check("pin_3m5", model(32'd3, 32'd5, 1'b0), 33'h1_000000F9);
`else
        check("pin_0m1", model(32'd0, 32'd1, 1'b0), 33'h1_FFFFFFFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        run_op(32'd5, 32'd3, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(32'd0, 32'd1, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(32'd5, 32'd3, 1'b1, 2, 2, 1'b0, 1'b0);
        run_op(32'd3, 32'd5, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(32'hA0B0C0D0, 32'h0A0B0C0D, 1'b1, 1, 1, 1'b0, 1'b0);
        run_op(32'd5, 32'd3, 1'b0, -1, 0, 1'b1, 1'b0);

        // Leave borrow_out=1, then reset mid-operation after digit 2.
        run_op(32'd0, 32'd1, 1'b0, -1, 0, 1'b0, 1'b0);
        check("bout_before_reset", borrow_out, 1);
        run_op(32'd0, 32'd1, 1'b0, -1, 0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset");
        rst = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("no_output_after_reset", digit_out_valid, 0);

        run_op(32'd5, 32'd3, 1'b0, -1, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
